// File: rtl/vga_pkg.sv
// Shared types and constant helpers for the VGA framebuffer controller:
// line/frame timing description, sync polarities, width helpers and swap FSM states.
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  localparam logic POL_ACTIVE_HIGH = 1'b1;
  localparam logic POL_ACTIVE_LOW  = 1'b0;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  function automatic int timing_total(vga_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam vga_timing_t DEF_H_TIMING = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
  localparam vga_timing_t DEF_V_TIMING = '{active: 16'd600, fp: 16'd1, sync: 16'd4, bp: 16'd23};
  localparam int DEF_HW = width_of(timing_total(DEF_H_TIMING));
  localparam int DEF_VW = width_of(timing_total(DEF_V_TIMING));

endpackage

// File: rtl/vga_fb_ctl_if.sv
// Write-side bus of the framebuffer controller: pixel writes, range error and
// the frame-synchronised buffer swap handshake.
interface vga_fb_ctl_if #(
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int COLOR_W = 24
) ();
  logic               wr_valid;
  logic [XW-1:0]      wr_x;
  logic [YW-1:0]      wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_err;
  logic               swap_req;
  logic               swap_done;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, swap_req,
    input  wr_err, swap_done
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, swap_req,
    output wr_err, swap_done
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters advancing on pix_en, with combinational
// active/sync decode of the current position and the frame-wrap tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t H_T    = DEF_H_TIMING,
  parameter vga_timing_t V_T    = DEF_V_TIMING,
  parameter logic        HS_POL = POL_ACTIVE_HIGH,
  parameter logic        VS_POL = POL_ACTIVE_HIGH,
  localparam int         HW     = width_of(timing_total(H_T)),
  localparam int         VW     = width_of(timing_total(V_T))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o
);
  localparam logic [HW-1:0] H_LAST = HW'(timing_total(H_T) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(timing_total(V_T) - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(int'(H_T.active));
  localparam logic [VW-1:0] V_ACT  = VW'(int'(V_T.active));
  localparam logic [HW-1:0] HS_S   = HW'(int'(H_T.active) + int'(H_T.fp));
  localparam logic [HW-1:0] HS_E   = HW'(int'(H_T.active) + int'(H_T.fp) + int'(H_T.sync) - 1);
  localparam logic [VW-1:0] VS_S   = VW'(int'(V_T.active) + int'(V_T.fp));
  localparam logic [VW-1:0] VS_E   = VW'(int'(V_T.active) + int'(V_T.fp) + int'(V_T.sync) - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Next counter position: h wraps into a v increment, v wraps at the frame end.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      h_d = h_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o       = ((h_q >= HS_S) && (h_q <= HS_E)) ? HS_POL : ~HS_POL;
  assign vsync_o       = ((v_q >= VS_S) && (v_q <= VS_E)) ? VS_POL : ~VS_POL;
  assign frame_start_o = pix_en_i && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_fb_ctl.sv
// VGA controller top: scaled, optionally double-buffered framebuffer RAM,
// display address generation, registered video outputs and the swap FSM.
module vga_fb_ctl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int COLOR_W     = 24,
  parameter int SCALE_SHIFT = 2,
  parameter int DOUBLE_BUF  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  vga_fb_ctl_if.slave        wr_bus,
  output logic               frame_start,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_blank_n
);
  localparam vga_timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int HW     = width_of(timing_total(H_T));
  localparam int VW     = width_of(timing_total(V_T));
  localparam int FB_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H   = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_PIX = FB_W * FB_H;
  localparam int DEPTH  = (1 + DOUBLE_BUF) * FB_PIX;
  localparam int AW     = width_of(DEPTH);
  // Coordinate ports can express FB_W/FB_H themselves so out-of-range writes are representable.
  localparam int XW     = width_of(FB_W + 1);
  localparam int YW     = width_of(FB_H + 1);
  localparam logic HS_POL_L = (HS_POL != 0) ? POL_ACTIVE_HIGH : POL_ACTIVE_LOW;
  localparam logic VS_POL_L = (VS_POL != 0) ? POL_ACTIVE_HIGH : POL_ACTIVE_LOW;
  localparam logic [AW-1:0] FB_W_A = AW'(FB_W);
  localparam logic [AW-1:0] BUF_A  = AW'(FB_PIX);

  logic [HW-1:0] h_s;
  logic [VW-1:0] v_s;
  logic          active_s, hsync_s, vsync_s, fstart_s;

  vga_timing_gen #(
    .H_T(H_T), .V_T(V_T), .HS_POL(HS_POL_L), .VS_POL(VS_POL_L)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en_i(pix_en),
    .h_o(h_s), .v_o(v_s), .active_o(active_s),
    .hsync_o(hsync_s), .vsync_o(vsync_s), .frame_start_o(fstart_s)
  );

  swap_state_e state_q, state_d;
  logic        front_q, front_d;
  logic        swap_done_s;

  // Swap FSM: a request arms the swap, the next frame wrap performs it.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_s = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (wr_bus.swap_req) begin
          state_d = SWAP_PENDING;
        end else begin
          state_d = SWAP_IDLE;
        end
      end
      SWAP_PENDING: begin
        if (fstart_s) begin
          state_d     = SWAP_IDLE;
          swap_done_s = 1'b1;
          front_d     = (DOUBLE_BUF != 0) ? ~front_q : front_q;
        end else begin
          state_d = SWAP_PENDING;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Swap FSM state and front-buffer select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SWAP_IDLE;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
    end
  end

  logic          back_sel_s, in_range_s, we_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s;

  assign back_sel_s = (DOUBLE_BUF != 0) ? ~front_q : front_q;
  assign in_range_s = (wr_bus.wr_x < XW'(FB_W)) && (wr_bus.wr_y < YW'(FB_H));
  assign we_s       = wr_bus.wr_valid && in_range_s;
  assign wr_addr_s  = (back_sel_s ? BUF_A : '0) + AW'(wr_bus.wr_y) * FB_W_A + AW'(wr_bus.wr_x);
  // Blanked positions read address 0; their data is masked at the output anyway.
  assign rd_addr_s  = active_s ? ((front_q ? BUF_A : '0) + AW'(v_s >> SCALE_SHIFT) * FB_W_A
                                  + AW'(h_s >> SCALE_SHIFT)) : '0;

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] rd_data_q;

  // Framebuffer RAM: writes any cycle, display read on pixel ticks returns pre-write data.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_addr_s] <= wr_bus.wr_color;
    end
    if (pix_en) begin
      rd_data_q <= mem_q[rd_addr_s];
    end
  end

  logic blank_n_q, hsync_q, vsync_q, wr_err_q;

  // Output stage aligned with the RAM read latency, plus the write error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_n_q <= 1'b0;
      hsync_q   <= ~HS_POL_L;
      vsync_q   <= ~VS_POL_L;
      wr_err_q  <= 1'b0;
    end else begin
      if (pix_en) begin
        blank_n_q <= active_s;
        hsync_q   <= hsync_s;
        vsync_q   <= vsync_s;
      end
      wr_err_q <= wr_bus.wr_valid && !in_range_s;
    end
  end

  assign vga_color        = blank_n_q ? rd_data_q : '0;
  assign vga_blank_n      = blank_n_q;
  assign vga_hsync        = hsync_q;
  assign vga_vsync        = vsync_q;
  assign frame_start      = fstart_s;
  assign wr_bus.wr_err    = wr_err_q;
  assign wr_bus.swap_done = swap_done_s;

endmodule

// File: tb/tb_vga_fb_ctl.sv
// Bench for vga_fb_ctl on a tiny 16x8 raster (4x2 framebuffer, 2x scaling),
// with a position-based display model checked every cycle plus directed literal checks.
module tb_vga_fb_ctl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        frame_start, vga_hsync, vga_vsync, vga_blank_n;
  logic [23:0] vga_color;
  int          checks = 0;
  int          failures = 0;

  vga_fb_ctl_if #(.XW(3), .YW(2), .COLOR_W(24)) bus ();

  vga_fb_ctl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(24), .SCALE_SHIFT(1), .DOUBLE_BUF(1)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .wr_bus(bus.slave),
    .frame_start(frame_start), .vga_color(vga_color), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); #2; pix_en = ~pix_en; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display model: tick count since reset, what the output register holds, buffers, swap state.
  int          m_t = 0, m_prev = -1, m_front = 0;
  bit          m_pending = 0, m_err = 0, m_known_prev = 0;
  logic [23:0] m_color_prev = 24'h0;
  logic [23:0] m_fb [16];
  bit          m_known [16];

  initial begin
    int pos, ph, pv, a;
    bit fs_e, hs_e, vs_e, bl_e, in_r;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_t = 0; m_prev = -1; m_front = 0; m_pending = 0; m_err = 0;
      end
      pos  = m_t % 128;
      fs_e = pix_en && !reset && (pos == 127);
      hs_e = 0; vs_e = 0; bl_e = 0;
      if (m_prev >= 0) begin
        ph = m_prev % 16; pv = m_prev / 16;
        hs_e = (ph >= 10) && (ph <= 12);
        vs_e = (pv >= 5) && (pv <= 6);
        bl_e = (ph < 8) && (pv < 4);
      end
      check("m_frame_start", {31'd0, frame_start}, {31'd0, fs_e});
      check("m_swap_done", {31'd0, bus.swap_done}, {31'd0, fs_e && m_pending});
      check("m_hsync", {31'd0, vga_hsync}, {31'd0, hs_e});
      check("m_vsync", {31'd0, vga_vsync}, {31'd0, vs_e});
      check("m_blank_n", {31'd0, vga_blank_n}, {31'd0, bl_e});
      check("m_wr_err", {31'd0, bus.wr_err}, {31'd0, m_err});
      if (!bl_e) check("m_color_blank", {8'd0, vga_color}, 32'd0);
      else if (m_known_prev) check("m_color", {8'd0, vga_color}, {8'd0, m_color_prev});
      @(posedge clk);
      if (!reset) begin
        in_r  = (bus.wr_x < 3'd4) && (bus.wr_y < 2'd2);
        m_err = bus.wr_valid && !in_r;
        if (pix_en) begin
          ph = pos % 16; pv = pos / 16;
          if (ph < 8 && pv < 4) begin
            a = m_front * 8 + (pv / 2) * 4 + ph / 2;
            m_color_prev = m_fb[a]; m_known_prev = m_known[a];
          end
          m_prev = pos; m_t++;
        end
        if (bus.wr_valid && in_r) begin
          a = (1 - m_front) * 8 + int'(bus.wr_y) * 4 + int'(bus.wr_x);
          m_fb[a] = bus.wr_color; m_known[a] = 1;
        end
        if (m_pending && pix_en && pos == 127) begin
          m_front = 1 - m_front; m_pending = 0;
        end else if (!m_pending && bus.swap_req) begin
          m_pending = 1;
        end
      end
    end
  end

  task automatic wr(input int x, input int y, input logic [23:0] c);
    @(posedge clk); #2;
    bus.wr_valid = 1'b1; bus.wr_x = 3'(x); bus.wr_y = 2'(y); bus.wr_color = c;
    @(posedge clk); #2;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 600);
    check(name, {31'd0, frame_start}, 32'd1);
  endtask

  task automatic ticks(input int k);
    int c = 0;
    while (c < k) begin @(posedge clk); if (pix_en) c++; end
  endtask

  // Leaves the bench at the negedge where the outputs show raster position pos.
  task automatic goto_pos(input int pos);
    wait_frame("frame_arrives");
    @(posedge clk);
    ticks(pos + 1);
    @(negedge clk);
  endtask

  task automatic do_swap();
    int n = 0;
    @(posedge clk); #2; bus.swap_req = 1'b1;
    @(posedge clk); #2; bus.swap_req = 1'b0;
    do begin @(negedge clk); n++; end while (!bus.swap_done && n < 600);
    check("swap_done_arrives", {31'd0, bus.swap_done}, 32'd1);
  endtask

  initial begin
    int n, bcnt, sdc, first, tk;
    bus.wr_valid = 1'b0; bus.wr_x = 3'd0; bus.wr_y = 2'd0; bus.wr_color = 24'h0;
    bus.swap_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hsync", {31'd0, vga_hsync}, 32'd0);
    check("rst_blank", {31'd0, vga_blank_n}, 32'd0);
    @(posedge clk); #2; reset = 1'b0;

    // Scaling: one red framebuffer pixel at (1,0) covers screen h=2,3 on v=0,1.
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        wr(x, y, (x == 1 && y == 0) ? 24'hFF0000 : 24'h00FF00);
    do_swap();
    goto_pos(2);  check("scale_h2v0", {8'd0, vga_color}, 32'hFF0000);
    goto_pos(19); check("scale_h3v1", {8'd0, vga_color}, 32'hFF0000);
    goto_pos(1);  check("scale_h1v0", {8'd0, vga_color}, 32'h00FF00);
    goto_pos(4);  check("scale_h4v0", {8'd0, vga_color}, 32'h00FF00);
    goto_pos(34); check("scale_h2v2", {8'd0, vga_color}, 32'h00FF00);

    // Timing landmarks and frame period.
    goto_pos(7);   check("blank_h7", {31'd0, vga_blank_n}, 32'd1);
    goto_pos(9);   check("hsync_h9", {31'd0, vga_hsync}, 32'd0);
    goto_pos(10);  check("hsync_h10", {31'd0, vga_hsync}, 32'd1);
                   check("blank_h10", {31'd0, vga_blank_n}, 32'd0);
    goto_pos(79);  check("vsync_v4", {31'd0, vga_vsync}, 32'd0);
    goto_pos(80);  check("vsync_v5", {31'd0, vga_vsync}, 32'd1);
    goto_pos(111); check("vsync_v6", {31'd0, vga_vsync}, 32'd1);
    goto_pos(112); check("vsync_v7", {31'd0, vga_vsync}, 32'd0);
    wait_frame("period_start");
    n = 0; bcnt = 0;
    do begin @(negedge clk); n++; if (vga_blank_n) bcnt++; end while (!frame_start && n < 600);
    check("frame_period_cycles", n, 32'd256);
    check("blank_cycles_per_frame", bcnt, 32'd64);

    // Double buffer: blue goes to the back buffer mid-frame; display changes only after swap.
    goto_pos(40);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        wr(x, y, 24'h0000FF);
    goto_pos(0); check("dbuf_before_swap", {8'd0, vga_color}, 32'h00FF00);
    do_swap();
    @(posedge clk); ticks(1); @(negedge clk);
    check("dbuf_after_swap", {8'd0, vga_color}, 32'h0000FF);

    // Swap request on the frame_start tick, plus an ignored repeat while pending.
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 600);
    #1; bus.swap_req = 1'b1;
    @(posedge clk); #2; bus.swap_req = 1'b0;
    n = 0; sdc = 0; first = 0;
    while (n < 556) begin
      @(negedge clk); n++;
      if (bus.swap_done) begin sdc++; if (first == 0) first = n; end
      if (n == 100) bus.swap_req = 1'b1;
      if (n == 101) bus.swap_req = 1'b0;
    end
    check("swap_edge_latency", first, 32'd256);
    check("swap_single_done", sdc, 32'd1);

    // Range: out-of-range writes flag an error and leave the aliased entry intact.
    wr(4, 0, 24'h123456);
    @(negedge clk); check("wr_err_x4", {31'd0, bus.wr_err}, 32'd1);
    @(negedge clk); check("wr_err_clear", {31'd0, bus.wr_err}, 32'd0);
    wr(0, 2, 24'h654321);
    @(negedge clk); check("wr_err_y2", {31'd0, bus.wr_err}, 32'd1);
    wr(3, 1, 24'h0000FF);
    @(negedge clk); check("wr_ok_no_err", {31'd0, bus.wr_err}, 32'd0);
    do_swap();
    goto_pos(32); check("range_no_alias", {8'd0, vga_color}, 32'h0000FF);

    // Reset mid-frame with a swap pending.
    goto_pos(50);
    @(posedge clk); #2; bus.swap_req = 1'b1;
    @(posedge clk); #2; bus.swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b1;
    #1;
    check("rst_mid_color", {8'd0, vga_color}, 32'd0);
    check("rst_mid_blank", {31'd0, vga_blank_n}, 32'd0);
    check("rst_mid_hsync", {31'd0, vga_hsync}, 32'd0);
    check("rst_mid_vsync", {31'd0, vga_vsync}, 32'd0);
    check("rst_mid_fstart", {31'd0, frame_start}, 32'd0);
    check("rst_mid_swap_done", {31'd0, bus.swap_done}, 32'd0);
    check("rst_mid_wr_err", {31'd0, bus.wr_err}, 32'd0);
    repeat (3) @(posedge clk);
    #2; reset = 1'b0;
    n = 0; tk = 0; sdc = 0;
    do begin
      @(negedge clk); n++;
      if (bus.swap_done) sdc++;
      if (!frame_start) begin @(posedge clk); if (pix_en) tk++; end
    end while (!frame_start && n < 600);
    check("rst_restart_ticks", tk, 32'd127);
    check("rst_no_swap_done", sdc, 32'd0);
    goto_pos(0); check("rst_front_buf0", {8'd0, vga_color}, 32'h0000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
